// File: rtl/modulo_arbitro_transferencia_rolhas.sv
// rtl/modulo_arbitro_transferencia_rolhas.sv - cork buffer arbiter and strobe sequencer
// ARB_XFER_PRIO_EN: refill transfer gets fixed priority over operator load (rr pointer unused)
module modulo_arbitro_transferencia_rolhas #(
  parameter int SEC_W    = 7,
  parameter int MAIN_W   = 5,
  parameter int SEC_MAX  = 99,
  parameter int MAIN_CAP = 31,
  parameter int BATCH    = 20
) (
  input  logic              clk,
  input  logic              clr,
  input  logic              op_req,
  input  logic [SEC_W-1:0]  op_qty,
  input  logic              xfer_req,
  input  logic              seal_busy,
  input  logic [SEC_W-1:0]  sec_level,
  input  logic [MAIN_W-1:0] main_level,
  output logic              sec_inc,
  output logic              sec_dec,
  output logic              main_inc,
  output logic              op_ack,
  output logic              xfer_ack,
  output logic              err,
  output logic [1:0]        state
);

  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    OP_LOAD = 2'b01,
    XFER    = 2'b10,
    DONE    = 2'b11
  } state_t;

  state_t           cur, nxt;
  logic [SEC_W-1:0] remaining, remaining_nxt;
  logic             rr_xfer, rr_xfer_nxt;
  logic             inc_q, inc_nxt, dec_q, dec_nxt;
  logic             op_ack_q, op_ack_nxt, xfer_ack_q, xfer_ack_nxt, err_q, err_nxt;
  logic             pick_xfer;
  logic [SEC_W:0]   op_sum;
  logic             op_bad;
  logic [SEC_W-1:0] room, xfer_n;

  always_comb begin
    op_sum = {1'b0, sec_level} + {1'b0, op_qty};
    op_bad = (op_qty == '0) || (op_sum > (SEC_W+1)'(SEC_MAX));
    room   = SEC_W'(MAIN_CAP) - SEC_W'(main_level);
    xfer_n = SEC_W'(BATCH);
    if (sec_level < xfer_n) xfer_n = sec_level;
    if (room < xfer_n) xfer_n = room;
  end

`ifdef ARB_XFER_PRIO_EN
  assign pick_xfer = xfer_req;
`else
  assign pick_xfer = xfer_req && (!op_req || rr_xfer);
`endif

  // Strobes are registered, so each cycle schedules the strobe of the following cycle;
  // a seal_busy cycle therefore suppresses the next transfer strobe.
  always_comb begin
    nxt           = cur;
    remaining_nxt = remaining;
    rr_xfer_nxt   = rr_xfer;
    inc_nxt       = 1'b0;
    dec_nxt       = 1'b0;
    op_ack_nxt    = 1'b0;
    xfer_ack_nxt  = 1'b0;
    err_nxt       = 1'b0;
    case (cur)
      IDLE: begin
        if (op_req || xfer_req) begin
          rr_xfer_nxt = !pick_xfer;
          if (pick_xfer) begin
            if (xfer_n == '0) begin
              nxt          = DONE;
              xfer_ack_nxt = 1'b1;
              err_nxt      = 1'b1;
            end else begin
              nxt           = XFER;
              remaining_nxt = xfer_n;
              dec_nxt       = !seal_busy;
            end
          end else begin
            if (op_bad) begin
              nxt        = DONE;
              op_ack_nxt = 1'b1;
              err_nxt    = 1'b1;
            end else begin
              nxt           = OP_LOAD;
              remaining_nxt = op_qty;
              inc_nxt       = 1'b1;
            end
          end
        end
      end
      OP_LOAD: begin
        if (remaining == SEC_W'(1)) begin
          nxt        = DONE;
          op_ack_nxt = 1'b1;
        end else begin
          remaining_nxt = remaining - SEC_W'(1);
          inc_nxt       = 1'b1;
        end
      end
      XFER: begin
        if (dec_q && remaining == SEC_W'(1)) begin
          nxt          = DONE;
          xfer_ack_nxt = 1'b1;
        end else begin
          if (dec_q) remaining_nxt = remaining - SEC_W'(1);
          dec_nxt = !seal_busy;
        end
      end
      DONE: begin
        nxt           = IDLE;
        remaining_nxt = '0;
      end
      default: nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      cur        <= IDLE;
      remaining  <= '0;
      rr_xfer    <= 1'b0;
      inc_q      <= 1'b0;
      dec_q      <= 1'b0;
      op_ack_q   <= 1'b0;
      xfer_ack_q <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      cur        <= nxt;
      remaining  <= remaining_nxt;
      rr_xfer    <= rr_xfer_nxt;
      inc_q      <= inc_nxt;
      dec_q      <= dec_nxt;
      op_ack_q   <= op_ack_nxt;
      xfer_ack_q <= xfer_ack_nxt;
      err_q      <= err_nxt;
    end
  end

  assign sec_inc  = inc_q;
  assign sec_dec  = dec_q;
  assign main_inc = dec_q;
  assign op_ack   = op_ack_q;
  assign xfer_ack = xfer_ack_q;
  assign err      = err_q;
  assign state    = cur;

endmodule

// File: tb/tb_modulo_arbitro_transferencia_rolhas.sv
// tb/tb_modulo_arbitro_transferencia_rolhas.sv - randomized self-checking bench for the cork arbiter
module tb_modulo_arbitro_transferencia_rolhas;

  logic       clk, clr, op_req, xfer_req, seal_busy;
  logic [6:0] op_qty, sec_level;
  logic [4:0] main_level;
  logic       sec_inc, sec_dec, main_inc, op_ack, xfer_ack, err;
  logic [1:0] state;
  int         n_vec = 0;
  int         n_bad = 0;

  modulo_arbitro_transferencia_rolhas dut (
    .clk(clk), .clr(clr), .op_req(op_req), .op_qty(op_qty), .xfer_req(xfer_req),
    .seal_busy(seal_busy), .sec_level(sec_level), .main_level(main_level),
    .sec_inc(sec_inc), .sec_dec(sec_dec), .main_inc(main_inc), .op_ack(op_ack),
    .xfer_ack(xfer_ack), .err(err), .state(state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: cycle 0 is the IDLE sampling cycle; a transfer strobe lands in cycle t
  // whenever seal_busy was low in cycle t-1, until n strobes have been issued.
  function automatic void model(input bit g_xfer, input logic [6:0] qty, input logic [6:0] sec,
                                input logic [4:0] mlev, input logic [127:0] seal,
                                output logic [127:0] e_inc, output logic [127:0] e_dec,
                                output int e_ack, output bit e_err);
    int n, cnt, t;
    e_inc = '0; e_dec = '0; e_err = 1'b0; e_ack = 1;
    if (!g_xfer) begin
      if (qty == 0 || int'(sec) + int'(qty) > 99) e_err = 1'b1;
      else begin
        for (int i = 1; i <= int'(qty); i++) e_inc[i] = 1'b1;
        e_ack = int'(qty) + 1;
      end
    end else begin
      n = 20;
      if (int'(sec) < n) n = int'(sec);
      if (31 - int'(mlev) < n) n = 31 - int'(mlev);
      if (n == 0) e_err = 1'b1;
      else begin
        cnt = 0; t = 1;
        while (cnt < n && t < 128) begin
          if (!seal[t-1]) begin e_dec[t] = 1'b1; cnt++; end
          t++;
        end
        e_ack = t;
      end
    end
  endfunction

  task automatic do_reset();
    clr = 1'b0; op_req = 1'b0; xfer_req = 1'b0; seal_busy = 1'b0;
    repeat (2) @(posedge clk);
    #1 clr = 1'b1;
  endtask

  // Drives one request episode starting in an IDLE cycle; returns per-cycle observations.
  task automatic run_txn(input bit rq_op, input bit rq_xfer, input logic [6:0] qty,
                         input logic [6:0] sec, input logic [4:0] mlev, input logic [127:0] seal,
                         output logic [127:0] o_inc, output logic [127:0] o_dec,
                         output logic [127:0] o_main, output int ack_c, output bit ack_op,
                         output bit ack_xf, output bit ack_err, output bit overlap);
    o_inc = '0; o_dec = '0; o_main = '0; ack_c = -1;
    ack_op = 1'b0; ack_xf = 1'b0; ack_err = 1'b0; overlap = 1'b0;
    if (rq_op) op_req = 1'b1;
    if (rq_xfer) xfer_req = 1'b1;
    op_qty = qty; sec_level = sec; main_level = mlev; seal_busy = seal[0];
    for (int c = 0; c < 128; c++) begin
      @(negedge clk);
      o_inc[c] = sec_inc; o_dec[c] = sec_dec; o_main[c] = main_inc;
      if (sec_inc && sec_dec) overlap = 1'b1;
      if (op_ack || xfer_ack) begin
        ack_c = c; ack_op = op_ack; ack_xf = xfer_ack; ack_err = err;
      end
      @(posedge clk);
      #1;
      if (ack_c >= 0) begin
        if (ack_op) op_req = 1'b0;
        if (ack_xf) xfer_req = 1'b0;
        seal_busy = 1'b0;
        break;
      end
      seal_busy = (c < 127) ? seal[c+1] : 1'b0;
    end
    if (ack_c < 0) begin op_req = 1'b0; xfer_req = 1'b0; seal_busy = 1'b0; end
  endtask

  task automatic test_reset();
    clr = 1'b0; op_req = 1'b0; xfer_req = 1'b0; seal_busy = 1'b0;
    op_qty = '0; sec_level = '0; main_level = '0;
    #3;
    n_vec++;
    if ({state, sec_inc, sec_dec, main_inc, op_ack, xfer_ack, err} !== 8'h00) begin
      n_bad++;
      $display("FAIL reset_outputs: got %b required 00000000",
               {state, sec_inc, sec_dec, main_inc, op_ack, xfer_ack, err});
    end
    repeat (2) @(posedge clk);
    #1 clr = 1'b1;
    @(negedge clk);
    n_vec++;
    if (state !== 2'b00 || sec_inc !== 1'b0 || op_ack !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_idle: state=%b sec_inc=%b op_ack=%b required 00 0 0", state, sec_inc, op_ack);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_op(input bit rejects);
    logic [127:0] seal, oi, od, om, ei, ed;
    logic [6:0]   q, s;
    int           ac, ea;
    bit           aop, axf, aer, ovl, eer;
    seal = '0;
    for (int k = 0; k < 6; k++) begin
      if (!rejects) begin
        case (k)
          0: begin q = 7'd5;  s = 7'd10; end
          1: begin q = 7'd59; s = 7'd40; end
          default: begin
            s = 7'($urandom_range(0, 90));
            q = 7'($urandom_range(1, 99 - int'(s)));
          end
        endcase
      end else begin
        case (k)
          0: begin q = 7'd95; s = 7'd10; end
          1: begin q = 7'd0;  s = 7'd50; end
          2: begin q = 7'd1;  s = 7'd99; end
          default: begin
            s = 7'($urandom_range(0, 99));
            q = 7'($urandom_range(100 - int'(s), 127));
          end
        endcase
      end
      run_txn(1'b1, 1'b0, q, s, 5'd3, seal, oi, od, om, ac, aop, axf, aer, ovl);
      model(1'b0, q, s, 5'd3, seal, ei, ed, ea, eer);
      n_vec++;
      if ({oi, od, om} !== {ei, ed, ed} || ovl) begin
        n_bad++;
        $display("FAIL op_strobes q=%0d s=%0d: inc=%h dec=%h main=%h required inc=%h dec/main=%h",
                 q, s, oi, od, om, ei, ed);
      end
      n_vec++;
      if (ac !== ea || aer !== eer || aop !== 1'b1 || axf !== 1'b0) begin
        n_bad++;
        $display("FAIL op_ack q=%0d s=%0d: cycle=%0d err=%b op=%b xf=%b required cycle=%0d err=%b op=1 xf=0",
                 q, s, ac, aer, aop, axf, ea, eer);
      end
    end
  endtask

  task automatic test_xfer(input bit stalls);
    logic [127:0] seal, oi, od, om, ei, ed;
    logic [6:0]   s;
    logic [4:0]   m;
    int           ac, ea;
    bit           aop, axf, aer, ovl, eer;
    for (int k = 0; k < 7; k++) begin
      seal = '0;
      case (k)
        0: begin s = 7'd30; m = 5'd4;  if (stalls) seal[8:6] = 3'b111; end
        1: begin s = 7'd7;  m = 5'd4;  if (stalls) seal[0] = 1'b1; end
        2: begin s = 7'd50; m = 5'd25; end
        3: begin s = 7'd30; m = 5'd31; end
        4: begin s = 7'd0;  m = 5'd10; end
        default: begin
          s = 7'($urandom_range(0, 99));
          m = 5'($urandom_range(0, 31));
        end
      endcase
      if (stalls && k >= 2)
        for (int i = 0; i < 128; i++) seal[i] = ($urandom_range(0, 2) == 0);
      run_txn(1'b0, 1'b1, 7'd0, s, m, seal, oi, od, om, ac, aop, axf, aer, ovl);
      model(1'b1, 7'd0, s, m, seal, ei, ed, ea, eer);
      n_vec++;
      if ({oi, od, om} !== {ei, ed, ed} || ovl) begin
        n_bad++;
        $display("FAIL xfer_strobes s=%0d m=%0d: inc=%h dec=%h main=%h required inc=0 dec/main=%h",
                 s, m, oi, od, om, ed);
      end
      n_vec++;
      if (ac !== ea || aer !== eer || axf !== 1'b1 || aop !== 1'b0) begin
        n_bad++;
        $display("FAIL xfer_ack s=%0d m=%0d: cycle=%0d err=%b op=%b xf=%b required cycle=%0d err=%b op=0 xf=1",
                 s, m, ac, aer, aop, axf, ea, eer);
      end
    end
  endtask

  task automatic test_arbitration();
    logic [127:0] seal, oi, od, om, ei, ed;
    int           ac, ea;
    bit           aop, axf, aer, ovl, eer, rr_next_xfer, gx;
    seal = '0;
    do_reset();
    rr_next_xfer = 1'b0;
    for (int k = 0; k < 3; k++) begin
`ifdef ARB_XFER_PRIO_EN
      gx = 1'b1;
`else
      gx = rr_next_xfer;
`endif
      rr_next_xfer = !gx;
      run_txn(1'b1, 1'b1, 7'd3, 7'd30, 5'd4, seal, oi, od, om, ac, aop, axf, aer, ovl);
      model(gx, 7'd3, 7'd30, 5'd4, seal, ei, ed, ea, eer);
      n_vec++;
      if (aop !== !gx || axf !== gx || ac !== ea || aer !== eer) begin
        n_bad++;
        $display("FAIL arb_grant round=%0d: op=%b xf=%b cycle=%0d required op=%b xf=%b cycle=%0d",
                 k, aop, axf, ac, !gx, gx, ea);
      end
      n_vec++;
      if ({oi, od, om} !== {ei, ed, ed}) begin
        n_bad++;
        $display("FAIL arb_strobes round=%0d: inc=%h dec=%h required inc=%h dec=%h", k, oi, od, ei, ed);
      end
    end
    op_req = 1'b0; xfer_req = 1'b0;
  endtask

  task automatic test_reset_mid();
    int cnt, seen;
    cnt = 0; seen = 0;
    op_req = 1'b0; xfer_req = 1'b1; sec_level = 7'd30; main_level = 5'd4; seal_busy = 1'b0;
    for (int c = 0; c < 40 && cnt < 4; c++) begin
      @(negedge clk);
      if (sec_dec) cnt++;
    end
    n_vec++;
    if (cnt !== 4) begin
      n_bad++;
      $display("FAIL midreset_start: strobes=%0d required 4", cnt);
    end
    @(posedge clk);
    #2 clr = 1'b0;
    #1;
    n_vec++;
    if ({state, sec_inc, sec_dec, main_inc, op_ack, xfer_ack, err} !== 8'h00) begin
      n_bad++;
      $display("FAIL midreset_outputs: got %b required 00000000",
               {state, sec_inc, sec_dec, main_inc, op_ack, xfer_ack, err});
    end
    xfer_req = 1'b0;
    @(posedge clk);
    #1 clr = 1'b1;
    for (int c = 0; c < 25; c++) begin
      @(negedge clk);
      if (op_ack || xfer_ack || sec_dec || main_inc || sec_inc) seen++;
    end
    n_vec++;
    if (seen !== 0 || state !== 2'b00) begin
      n_bad++;
      $display("FAIL midreset_no_ack: active_cycles=%0d state=%b required 0 and 00", seen, state);
    end
  endtask

  initial begin
    clr = 1'b0; op_req = 1'b0; xfer_req = 1'b0; seal_busy = 1'b0;
    op_qty = '0; sec_level = '0; main_level = '0;
    test_reset();
    test_op(1'b0);
    test_op(1'b1);
    test_xfer(1'b0);
    test_xfer(1'b1);
    test_arbitration();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
